// File: rtl/uart_fifo_pkg.sv
// Shared constants and helpers for the parametrised UART FIFO.
package uart_fifo_pkg;

  localparam int OVW_DROP   = 0;
  localparam int OVW_OLDEST = 1;

  function automatic int level_width(input int addr_bits);
    return addr_bits + 1;
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] value);
    if (value == 16'hFFFF) begin
      return value;
    end else begin
      return value + 16'd1;
    end
  endfunction

endpackage

// File: rtl/uart_fifo_mem.sv
// DEPTH x DATA_WIDTH storage: synchronous write port, asynchronous read port.
module uart_fifo_mem #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_BITS  = 4
) (
  input  logic                  clock,
  input  logic                  we_i,
  input  logic [ADDR_BITS-1:0]  waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [ADDR_BITS-1:0]  raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  localparam int DEPTH = 1 << ADDR_BITS;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  // Write port; contents are intentionally not reset.
  always_ff @(posedge clock) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/uart_fifo_ctrl.sv
// Show-ahead synchronous FIFO with thresholds, occupancy and overflow/underflow pulses.
// Define FIFO_STATS_EN to add drop_count and peak_level statistics outputs.
module uart_fifo_ctrl
  import uart_fifo_pkg::*;
#(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDR_BITS     = 4,
  parameter int AFULL_THRESH  = 14,
  parameter int AEMPTY_THRESH = 2,
  parameter int OVERWRITE     = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  write_flag,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  read_next,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  empty_flag,
  output logic                  full_flag,
  output logic                  almost_empty,
  output logic                  almost_full,
  output logic [ADDR_BITS:0]    level,
  output logic                  overflow,
  output logic                  underflow
`ifdef FIFO_STATS_EN
  ,
  output logic [15:0]           drop_count,
  output logic [ADDR_BITS:0]    peak_level
`endif
);

  localparam int LW = level_width(ADDR_BITS);
  localparam logic [LW-1:0] DEPTH_L = LW'(1 << ADDR_BITS);

  logic [ADDR_BITS-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_BITS-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]        level_q, level_d;
  logic                 overflow_q, overflow_d;
  logic                 underflow_q, underflow_d;
  logic                 do_write_s, do_pop_s, rd_ok_s, mem_we_s;

  assign empty_flag   = (level_q == LW'(0));
  assign full_flag    = (level_q == DEPTH_L);
  assign almost_empty = (level_q <= LW'(AEMPTY_THRESH));
  assign almost_full  = (level_q >= LW'(AFULL_THRESH));
  assign level        = level_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

  // Decide store/pop per edge; overwrite-oldest turns a full write into store plus pop.
  always_comb begin
    rd_ok_s    = read_next && !empty_flag;
    do_write_s = 1'b0;
    do_pop_s   = rd_ok_s;
    if (write_flag) begin
      if (!full_flag || read_next) begin
        do_write_s = 1'b1;
      end else if (OVERWRITE == OVW_OLDEST) begin
        do_write_s = 1'b1;
        do_pop_s   = 1'b1;
      end else begin
        do_write_s = 1'b0;
      end
    end else begin
      do_write_s = 1'b0;
    end

    case ({do_write_s, do_pop_s})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase

    if (do_write_s) begin
      wr_ptr_d = wr_ptr_q + ADDR_BITS'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (do_pop_s) begin
      rd_ptr_d = rd_ptr_q + ADDR_BITS'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    overflow_d  = write_flag && full_flag && !read_next;
    underflow_d = read_next && empty_flag;
  end

  // State registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q    <= ADDR_BITS'(0);
      rd_ptr_q    <= ADDR_BITS'(0);
      level_q     <= LW'(0);
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign mem_we_s = do_write_s && !reset;

  uart_fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_BITS  (ADDR_BITS)
  ) u_mem (
    .clock   (clock),
    .we_i    (mem_we_s),
    .waddr_i (wr_ptr_q),
    .wdata_i (data_in),
    .raddr_i (rd_ptr_q),
    .rdata_o (data_out)
  );

`ifdef FIFO_STATS_EN
  logic [15:0]   drop_count_q, drop_count_d;
  logic [LW-1:0] peak_level_q, peak_level_d;

  // Saturating drop counter and high-water mark of occupancy.
  always_comb begin
    if (overflow_d) begin
      drop_count_d = sat_inc16(drop_count_q);
    end else begin
      drop_count_d = drop_count_q;
    end
    if (level_d > peak_level_q) begin
      peak_level_d = level_d;
    end else begin
      peak_level_d = peak_level_q;
    end
  end

  // Statistics registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      drop_count_q <= 16'd0;
      peak_level_q <= LW'(0);
    end else begin
      drop_count_q <= drop_count_d;
      peak_level_q <= peak_level_d;
    end
  end

  assign drop_count = drop_count_q;
  assign peak_level = peak_level_q;
`endif

endmodule

// File: tb/tb_uart_fifo_ctrl.sv
// Scoreboard bench: two instances (overwrite-oldest, drop-newest) against a list-based FIFO model.
module tb_uart_fifo_ctrl;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       write_flag = 1'b0;
  logic       read_next = 1'b0;
  logic [7:0] data_in = 8'd0;

  logic [7:0] dout_a, dout_b;
  logic       emp_a, ful_a, ae_a, af_a, of_a, uf_a;
  logic       emp_b, ful_b, ae_b, af_b, of_b, uf_b;
  logic [4:0] lvl_a, lvl_b;
  logic [15:0] dc_a, dc_b;
  logic [4:0]  pk_a, pk_b;

  always #5 clock = ~clock;

  uart_fifo_ctrl #(.DATA_WIDTH(8), .ADDR_BITS(4), .AFULL_THRESH(14), .AEMPTY_THRESH(2), .OVERWRITE(1)) u_ovw (
    .clock(clock), .reset(reset), .write_flag(write_flag), .data_in(data_in), .read_next(read_next),
    .data_out(dout_a), .empty_flag(emp_a), .full_flag(ful_a), .almost_empty(ae_a), .almost_full(af_a),
    .level(lvl_a), .overflow(of_a), .underflow(uf_a)
`ifdef FIFO_STATS_EN
    , .drop_count(dc_a), .peak_level(pk_a)
`endif
  );

  uart_fifo_ctrl #(.DATA_WIDTH(8), .ADDR_BITS(4), .AFULL_THRESH(14), .AEMPTY_THRESH(2), .OVERWRITE(0)) u_drop (
    .clock(clock), .reset(reset), .write_flag(write_flag), .data_in(data_in), .read_next(read_next),
    .data_out(dout_b), .empty_flag(emp_b), .full_flag(ful_b), .almost_empty(ae_b), .almost_full(af_b),
    .level(lvl_b), .overflow(of_b), .underflow(uf_b)
`ifdef FIFO_STATS_EN
    , .drop_count(dc_b), .peak_level(pk_b)
`endif
  );

`ifndef FIFO_STATS_EN
  assign dc_a = 16'd0;
  assign dc_b = 16'd0;
  assign pk_a = 5'd0;
  assign pk_b = 5'd0;
`endif

  typedef struct {
    int lvl;
    bit e, f, ae, af, of, uf, hv;
    int head;
    int drops;
    int peak;
  } exp_t;

  exp_t exp_q0[$];
  exp_t exp_q1[$];

  logic [7:0] mdl [2][16];
  int mcnt [2];
  int mdrop [2];
  int mpeak [2];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, expv, $time);
    end
  endtask

  task automatic m_pop(input int k);
    for (int i = 0; i < 15; i++) mdl[k][i] = mdl[k][i+1];
    mcnt[k]--;
  endtask

  task automatic m_push(input int k, input logic [7:0] d);
    mdl[k][mcnt[k]] = d;
    mcnt[k]++;
  endtask

  // Reference model: a FIFO list with head at index 0.
  task automatic model_step(input int k, input bit ovw, input bit rst, input bit wr, input bit rd,
                            input logic [7:0] d, output exp_t e);
    e.of = 1'b0;
    e.uf = 1'b0;
    if (rst) begin
      mcnt[k] = 0; mdrop[k] = 0; mpeak[k] = 0;
    end else begin
      e.uf = rd && (mcnt[k] == 0);
      e.of = wr && (mcnt[k] == 16) && !rd;
      if (rd && mcnt[k] > 0) m_pop(k);
      if (wr) begin
        if (mcnt[k] < 16) m_push(k, d);
        else if (ovw) begin m_pop(k); m_push(k, d); end
      end
      if (e.of && mdrop[k] < 65535) mdrop[k]++;
      if (mcnt[k] > mpeak[k]) mpeak[k] = mcnt[k];
    end
    e.lvl = mcnt[k];
    e.e = (mcnt[k] == 0);
    e.f = (mcnt[k] == 16);
    e.ae = (mcnt[k] <= 2);
    e.af = (mcnt[k] >= 14);
    e.hv = (mcnt[k] > 0);
    e.head = int'(mdl[k][0]);
    e.drops = mdrop[k];
    e.peak = mpeak[k];
  endtask

  task automatic cyc(input bit rst, input bit wr, input bit rd, input logic [7:0] d);
    exp_t e0, e1;
    @(negedge clock);
    reset = rst; write_flag = wr; read_next = rd; data_in = d;
    model_step(0, 1'b1, rst, wr, rd, d, e0);
    model_step(1, 1'b0, rst, wr, rd, d, e1);
    exp_q0.push_back(e0);
    exp_q1.push_back(e1);
  endtask

  task automatic cmp(input string tag, input exp_t e, input logic [4:0] lv, input logic emp, input logic ful,
                     input logic ae, input logic af, input logic of, input logic uf, input logic [7:0] dout,
                     input logic [15:0] dc, input logic [4:0] pk);
    chk({tag, " level"}, 32'(lv), 32'(e.lvl));
    chk({tag, " empty"}, 32'(emp), 32'(e.e));
    chk({tag, " full"}, 32'(ful), 32'(e.f));
    chk({tag, " almost_empty"}, 32'(ae), 32'(e.ae));
    chk({tag, " almost_full"}, 32'(af), 32'(e.af));
    chk({tag, " overflow"}, 32'(of), 32'(e.of));
    chk({tag, " underflow"}, 32'(uf), 32'(e.uf));
    if (e.hv) chk({tag, " data_out"}, 32'(dout), 32'(e.head));
`ifdef FIFO_STATS_EN
    chk({tag, " drop_count"}, 32'(dc), 32'(e.drops));
    chk({tag, " peak_level"}, 32'(pk), 32'(e.peak));
`else
    if (dc !== 16'd0 || pk !== 5'd0) chk({tag, " stats tie"}, 32'(dc), 32'd0);
`endif
  endtask

  // Monitor: pops one expectation per instance after each active edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clock);
      #2;
      if (exp_q0.size() > 0) begin
        e = exp_q0.pop_front();
        cmp("ovw", e, lvl_a, emp_a, ful_a, ae_a, af_a, of_a, uf_a, dout_a, dc_a, pk_a);
      end
      if (exp_q1.size() > 0) begin
        e = exp_q1.pop_front();
        cmp("drop", e, lvl_b, emp_b, ful_b, ae_b, af_b, of_b, uf_b, dout_b, dc_b, pk_b);
      end
    end
  end

  initial begin
    int pw, pr;
    cyc(1'b1, 1'b0, 1'b0, 8'd0);
    cyc(1'b1, 1'b1, 1'b1, 8'hEE);
    // Fill to full, then drain.
    for (int i = 1; i <= 16; i++) cyc(1'b0, 1'b1, 1'b0, 8'(i));
    for (int i = 0; i < 16; i++) cyc(1'b0, 1'b0, 1'b1, 8'd0);
    // Full-write policy, then drain past empty.
    for (int i = 1; i <= 16; i++) cyc(1'b0, 1'b1, 1'b0, 8'(i));
    cyc(1'b0, 1'b1, 1'b0, 8'hAA);
    cyc(1'b0, 1'b0, 1'b0, 8'd0);
    cyc(1'b0, 1'b1, 1'b1, 8'hBB);
    for (int i = 0; i < 17; i++) cyc(1'b0, 1'b0, 1'b1, 8'd0);
    // Underflow alone and combined with a write into empty.
    cyc(1'b0, 1'b0, 1'b1, 8'd0);
    cyc(1'b0, 1'b1, 1'b1, 8'h55);
    cyc(1'b0, 1'b0, 1'b1, 8'd0);
    // Pointer wrap at constant level 3.
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b0, 8'($urandom));
    for (int i = 0; i < 40; i++) cyc(1'b0, 1'b1, 1'b1, 8'($urandom));
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b1, 8'd0);
    // Randomised traffic with varying write/read bias.
    for (int blk = 0; blk < 4; blk++) begin
      pw = (blk == 0) ? 80 : (blk == 1) ? 20 : (blk == 2) ? 50 : 90;
      pr = (blk == 0) ? 20 : (blk == 1) ? 80 : (blk == 2) ? 50 : 90;
      for (int i = 0; i < 100; i++)
        cyc(1'b0, $urandom_range(99) < pw, $urandom_range(99) < pr, 8'($urandom));
    end
    // Mid-stream reset at level 7 with a concurrent write.
    cyc(1'b1, 1'b0, 1'b0, 8'd0);
    for (int i = 0; i < 7; i++) cyc(1'b0, 1'b1, 1'b0, 8'(8'h30 + i));
    cyc(1'b1, 1'b1, 1'b0, 8'h77);
    cyc(1'b0, 1'b0, 1'b0, 8'd0);
    cyc(1'b0, 1'b1, 1'b0, 8'h99);
    cyc(1'b0, 1'b0, 1'b0, 8'd0);
    repeat (3) @(negedge clock);
    write_flag = 1'b0; read_next = 1'b0;
    chk("scoreboard drained", 32'(exp_q0.size() + exp_q1.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
